// File: rtl/sam_pkg.sv
// Shared definitions for the sequential signed shift-and-accumulate multiplier.
package sam_pkg;

  // Default operand width; the product is twice this wide.
  localparam int unsigned SAM_WIDTH = 32;

  // Controller states: wait for operands, iterate, fix sign, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : sam_pkg

// File: rtl/sam_step.sv
// One combinational add/shift iteration of the unsigned magnitude multiply.
module sam_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  // Add the shifted multiplicand when the current multiplier bit is set, then shift both.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule : sam_step

// File: rtl/sam_seq_mult.sv
// Sequential signed multiplier: multiplies operand magnitudes one bit per clock,
// then negates the accumulated product when the operand signs differ.
module sam_seq_mult
  import sam_pkg::*;
#(
  parameter int unsigned WIDTH = SAM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 sign
);

  localparam int unsigned        CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   OP_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ACC_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        cnt_r;
  logic                 sign_r;
  logic                 in_ready_r;
  logic                 out_valid_r;

  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic [2*WIDTH-1:0]   mcand_next_s;
  logic [WIDTH-1:0]     mplier_next_s;

  // Unsigned magnitudes of the operands; the most negative value maps to 2^(WIDTH-1) exactly.
  always_comb begin
    mag_a_s = a;
    mag_b_s = b;
    if (a[WIDTH-1]) begin
      mag_a_s = (~a) + OP_ONE;
    end else begin
      mag_a_s = a;
    end
    if (b[WIDTH-1]) begin
      mag_b_s = (~b) + OP_ONE;
    end else begin
      mag_b_s = b;
    end
  end

  sam_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc         (acc_r),
    .mcand       (mcand_r),
    .mplier      (mplier_r),
    .acc_next    (acc_next_s),
    .mcand_next  (mcand_next_s),
    .mplier_next (mplier_next_s)
  );

  // Controller FSM with all datapath registers and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      cnt_r       <= '0;
      sign_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            mcand_r    <= {{WIDTH{1'b0}}, mag_a_s};
            mplier_r   <= mag_b_s;
            sign_r     <= a[WIDTH-1] ^ b[WIDTH-1];
            acc_r      <= '0;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_next_s;
          mplier_r <= mplier_next_s;
          if (cnt_r == CNT_LAST) begin
            // Counter parks at its last value; the step count is fixed.
            state_r <= NEG;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        NEG: begin
          if (sign_r) begin
            acc_r <= (~acc_r) + ACC_ONE;
          end
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = acc_r;
  assign sign      = sign_r;

endmodule : sam_seq_mult

// File: tb/tb_sam_seq_mult.sv
// Self-checking bench for sam_seq_mult: directed vector table, stall/reset
// sequences and a long random run, all results checked through a scoreboard.
module tb_sam_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        sign;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_result;
    logic        exp_sign;
  } vec_t;

  typedef struct {
    logic [63:0] r;
    logic        s;
  } exp_t;

  vec_t        vecs [8];
  exp_t        sb [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  logic [63:0] last_result = 64'd0;
  logic        last_sign = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  sam_seq_mult #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sign      (sign)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: push reference on each accepted operand pair, pop and compare on each result handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        mon_e.r = longint'($signed(a)) * longint'($signed(b));
        mon_e.s = a[31] ^ b[31];
        sb.push_back(mon_e);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h required=none", result);
        end else begin
          mon_e = sb.pop_front();
          check("sb_result", result, mon_e.r);
          check("sb_sign", {63'd0, sign}, {63'd0, mon_e.s});
          last_result = result;
          last_sign   = sign;
          done_count++;
        end
      end
    end
  end

  // Present an operand pair and hold in_valid until it is accepted.
  task automatic start_op(input logic [31:0] aa, input logic [31:0] bb);
    int t;
    t = 0;
    a = aa;
    b = bb;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Count edges after acceptance until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int base;
    vecs[0] = '{32'd6,          32'd7,          64'd42,                 1'b0};
    vecs[1] = '{32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1,  1'b1};
    vecs[2] = '{32'h80000000,   32'h80000000,   64'h40000000_00000000,  1'b0};
    vecs[3] = '{32'h80000000,   32'd1,          64'hFFFFFFFF_80000000,  1'b1};
    vecs[4] = '{32'd0,          32'hFFFFFFFB,   64'd0,                  1'b1};
    vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'd1,                  1'b0};
    vecs[6] = '{32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF_00000001,  1'b0};
    vecs[7] = '{32'h7FFFFFFF,   32'h80000000,   64'hC0000000_80000000,  1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_sign", {63'd0, sign}, 64'd0);
    rst = 1'b0;

    // Directed vector table with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check("latency", 64'(lat), 64'd33);
      @(posedge clk);
      #1;
      check("tbl_result", last_result, vecs[i].exp_result);
      check("tbl_sign", {63'd0, last_sign}, {63'd0, vecs[i].exp_sign});
      check("tbl_in_ready", {63'd0, in_ready}, 64'd1);
    end

    // Consumer stalls in DONE; outputs must hold and new operands are ignored.
    out_ready = 1'b0;
    start_op(32'hFFFFFFFA, 32'd7);
    wait_valid(lat);
    for (int k = 0; k < 10; k++) begin
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", result, 64'hFFFFFFFF_FFFFFFD6);
      check("hold_sign", {63'd0, sign}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      if (k == 3) begin
        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    check("release_out_valid", {63'd0, out_valid}, 64'd0);
    check("release_result", last_result, 64'hFFFFFFFF_FFFFFFD6);

    // Reset in the middle of RUN aborts the operation.
    start_op(32'hFFFFFFFA, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_sign", {63'd0, sign}, 64'd0);
    start_op(32'd6, 32'd7);
    wait_valid(lat);
    check("post_abort_latency", 64'(lat), 64'd33);
    @(posedge clk);
    #1;
    check("post_abort_result", last_result, 64'd42);

    // Random operands with random producer gaps and consumer stalls.
    base = done_count;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          start_op($urandom, $urandom);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (done_count < base + 1000 && cyc < 60000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("rand_count", 64'(done_count - base), 64'd1000);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sam_seq_mult
